stn_cap: RTL and testbench
==========================

Name: stn_cap

Overview:
- Capture side of the LCD line/frame buffer.
- Samples the STN panel stream (FPFRAME, FPLINE, FPSHIFT, 4-bit data) produced by the S1D13700 core, packs nibbles into bytes and writes them into the shared buffer RAM over a req/ack write port.
- The TFT timing generator later reads the buffer back over the matching read port.
- Runs on the system clk; all STN inputs are asynchronous to clk.

Parameters:
- AW, 13, buffer address width.
- BUF_LAST, 13'h17BF, last valid buffer address; write address wraps to 0 after it.
- HOLD_DEPTH, 2, byte holding queue entries (fixed at 2; other values unsupported).

Ports:
- clk  input  1  system clock.
- rst_x  input  1  reset.
- reg_tcr  input  8  total character bytes per row (valid bytes per STN line).
- stn_fpframe  input  1  STN frame pulse, high active, asynchronous.
- stn_fpline  input  1  STN line pulse, high active, asynchronous.
- stn_fpshift  input  1  STN shift clock; data valid at falling edge.
- stn_fpdat  input  4  STN pixel data, MSB = leftmost pixel.
- buf_wrreq  output  1  buffer write request, high.
- buf_wrack  input  1  buffer write acknowledge, high.
- buf_waddr  output  AW  buffer write address.
- buf_wdata  output  8  buffer write data.
- frame_start  output  1  one-clk pulse at detected frame start.
- ovf_err  output  1  sticky overflow flag.

Behaviour:
- Reset: rst_x, asynchronous, active-low; clock clk. All registers clear.
  - Outputs at reset: buf_wrreq=0, buf_waddr=0, buf_wdata=0, frame_start=0, ovf_err=0.
  - Holding queue empty, nibble phase=0, column count=0.
- Sync:
  - fpframe, fpline and fpshift each pass through 3 flops (s[0]..s[2]).
  - stn_fpdat passes through 2 flops, so it is aligned with fpshift s[1].
- Edge detect:
  - shift_fall = s[2] & ~s[1].
  - line_fall = fpline s[2] & ~s[1].
  - Fall-to-capture latency is 3 clk.
- Frame start is line_fall with synchronized fpframe high.
  - Pulses frame_start for 1 clk.
  - Write pointer returns to 0.
  - Nibble phase and column count clear.
  - ovf_err clears.
  - Holding queue flushes; any in-flight request is dropped, and buf_wrreq deasserts next clk.
- Line end: line_fall without fpframe clears nibble phase and column count. A half-assembled byte is discarded.
- Packing:
  - On shift_fall, phase 0 stores data into byte[7:4].
  - Phase 1 stores data into byte[3:0] and completes the byte.
  - Phase toggles on each shift_fall.
- Column gate:
  - Completed bytes increment the column count, which saturates at 8'hFF.
  - Only bytes with column count < reg_tcr (before increment) are pushed; extra bytes are discarded silently.
  - reg_tcr=0 discards all bytes.
- Holding queue: 2-entry FIFO of bytes.
  - Push of a completed byte when the queue is full: byte dropped, ovf_err set to 1 (sticky until next frame start).
  - Push and pop in the same clk while full: push is accepted.
- Write FSM:
  - IDLE: when the queue is non-empty, load buf_wdata from the queue head, assert buf_wrreq, go to REQ.
  - REQ:
    - buf_wrreq, buf_waddr and buf_wdata are held stable until buf_wrack is sampled 1.
    - On ack: pop the queue; buf_waddr = (buf_waddr==BUF_LAST) ? 0 : buf_waddr+1.
    - After ack, if the queue still holds data, go directly to REQ with the next byte (back-to-back, no idle cycle). Otherwise deassert buf_wrreq and go to IDLE.
  - An ack while buf_wrreq=0 is ignored.
- Address arithmetic is AW-bit unsigned. The wrap compare is ==BUF_LAST; an address above BUF_LAST (only possible by fault) wraps to 0 on the next ack.
- Minimum ack latency is 0 clk: a combinational same-cycle ack is allowed.

Optional Feature:
- STN_CAP_INVERT_EN:
  - Defined: each packed byte is bitwise inverted before entering the holding queue (supports panels with reverse polarity).
  - Undefined: data is written unmodified.
  - Column gating, addressing and overflow behaviour are identical in both builds.

Test Plan:
- Reset, then frame start, then 2 shift falls with nibbles A,5; buf_wrack tied 1 -> one write of 0xA5 at addr 0; buf_waddr=1 after ack.
- reg_tcr=2, one line of 6 nibbles 1,2,3,4,5,6 -> writes 0x12, 0x34 only; third byte 0x56 discarded; ovf_err=0.
- buf_wrack held 0, 3 bytes completed -> first 2 bytes queued, third dropped, ovf_err=1; next frame start clears ovf_err=0 and buf_waddr=0.
- Preload pointer to BUF_LAST (0x17BF, reached by writing 0x17BF bytes), one more byte acked -> written at 0x17BF; next address 0x0000.
- Frame start asserted while buf_wrreq=1 awaiting ack -> buf_wrreq=0 next clk, queue empty, frame_start pulses 1 clk, no write issued for the flushed byte.
- STN_CAP_INVERT_EN defined, nibbles F,0 -> buf_wdata=0x0F; undefined -> 0xF0.

Source files
------------

// File: rtl/stn_cap.sv
// STN capture: syncs the panel stream, packs nibbles into bytes and writes them to the line buffer.
// Build option: define STN_CAP_INVERT_EN to invert each packed byte before it is queued.
module stn_cap #(
    parameter int unsigned    AW         = 13,
    parameter logic [AW-1:0]  BUF_LAST   = 13'h17BF,
    parameter int unsigned    HOLD_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_x,
    input  logic [7:0]    reg_tcr,
    input  logic          stn_fpframe,
    input  logic          stn_fpline,
    input  logic          stn_fpshift,
    input  logic [3:0]    stn_fpdat,
    output logic          buf_wrreq,
    input  logic          buf_wrack,
    output logic [AW-1:0] buf_waddr,
    output logic [7:0]    buf_wdata,
    output logic          frame_start,
    output logic          ovf_err
);

    typedef enum logic {StIdle, StReq} wr_state_e;

    localparam logic [1:0] QFULL = 2'(HOLD_DEPTH);

    logic [2:0] frame_s, line_s, shift_s;
    logic [3:0] dat_s0, dat_s1;

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            frame_s <= '0;
            line_s  <= '0;
            shift_s <= '0;
            dat_s0  <= '0;
            dat_s1  <= '0;
        end else begin
            frame_s <= {frame_s[1:0], stn_fpframe};
            line_s  <= {line_s[1:0], stn_fpline};
            shift_s <= {shift_s[1:0], stn_fpshift};
            dat_s0  <= stn_fpdat;
            dat_s1  <= dat_s0;
        end
    end

    logic line_fall, shift_fall, frame_evt;
    assign line_fall  = line_s[2] & ~line_s[1];
    assign shift_fall = shift_s[2] & ~shift_s[1];
    assign frame_evt  = line_fall & frame_s[2];

    logic       phase_q;
    logic [3:0] nib_q;
    logic [7:0] col_q;

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            phase_q <= 1'b0;
            nib_q   <= '0;
            col_q   <= '0;
        end else if (line_fall) begin
            phase_q <= 1'b0;
            col_q   <= '0;
        end else if (shift_fall) begin
            phase_q <= ~phase_q;
            if (!phase_q) begin
                nib_q <= dat_s1;
            end else if (col_q != 8'hFF) begin
                col_q <= col_q + 8'd1;
            end
        end
    end

    logic [7:0] byte_val;
    logic       push_req;
`ifdef STN_CAP_INVERT_EN
    assign byte_val = ~{nib_q, dat_s1};
`else
    assign byte_val = {nib_q, dat_s1};
`endif
    // A line/frame pulse in the same clk as the second nibble wins; the byte is lost.
    assign push_req = shift_fall & phase_q & ~line_fall & (col_q < reg_tcr);

    wr_state_e     state_q, state_d;
    logic [7:0]    mem_q [HOLD_DEPTH];
    logic          rd_ptr_q, wr_ptr_q;
    logic [1:0]    cnt_q, cnt_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          ovf_q, fs_q;
    logic          pop, push, full, ovf_set;

    always_comb begin
        full    = (cnt_q == QFULL);
        pop     = (state_q == StReq) & buf_wrack;
        push    = push_req & (~full | pop);
        ovf_set = push_req & full & ~pop;
        cnt_d   = cnt_q + {1'b0, push} - {1'b0, pop};
        state_d = state_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (cnt_q != 2'd0) begin
                    wdata_d = mem_q[rd_ptr_q];
                    state_d = StReq;
                end
            end
            StReq: begin
                if (pop) begin
                    waddr_d = (waddr_q == BUF_LAST) ? '0 : waddr_q + 1'b1;
                    // Back-to-back: next head is either the other entry or the byte arriving now.
                    if (cnt_q > 2'd1) begin
                        wdata_d = mem_q[~rd_ptr_q];
                    end else if (push) begin
                        wdata_d = byte_val;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state_q  <= StIdle;
            for (int i = 0; i < int'(HOLD_DEPTH); i++) mem_q[i] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            ovf_q    <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            fs_q <= frame_evt;
            if (frame_evt) begin
                state_q  <= StIdle;
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
                cnt_q    <= '0;
                waddr_q  <= '0;
                ovf_q    <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                waddr_q  <= waddr_d;
                wdata_q  <= wdata_d;
                rd_ptr_q <= rd_ptr_q ^ pop;
                wr_ptr_q <= wr_ptr_q ^ push;
                if (push) mem_q[wr_ptr_q] <= byte_val;
                if (ovf_set) ovf_q <= 1'b1;
            end
        end
    end

    assign buf_wrreq   = (state_q == StReq);
    assign buf_waddr   = waddr_q;
    assign buf_wdata   = wdata_q;
    assign frame_start = fs_q;
    assign ovf_err     = ovf_q;

endmodule

// File: tb/tb_stn_cap.sv
// Randomized scoreboard bench for stn_cap; expected writes come from a line/byte-level model.
module tb_stn_cap;

    localparam int AW = 13;
    localparam int BUF_WORDS = 13'h17BF + 1;

    logic          clk = 1'b0;
    logic          rst_x = 1'b0;
    logic [7:0]    reg_tcr = '0;
    logic          stn_fpframe = 1'b0, stn_fpline = 1'b0, stn_fpshift = 1'b0;
    logic [3:0]    stn_fpdat = '0;
    logic          buf_wrreq, buf_wrack = 1'b0;
    logic [AW-1:0] buf_waddr;
    logic [7:0]    buf_wdata;
    logic          frame_start, ovf_err;

    stn_cap dut (
        .clk(clk), .rst_x(rst_x), .reg_tcr(reg_tcr),
        .stn_fpframe(stn_fpframe), .stn_fpline(stn_fpline), .stn_fpshift(stn_fpshift),
        .stn_fpdat(stn_fpdat), .buf_wrreq(buf_wrreq), .buf_wrack(buf_wrack),
        .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
        .frame_start(frame_start), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int ack_mode = 0;          // 0: held low, 1: tied high, 2: random (never low >3 clk)
    int frames = 0, fs_high = 0;
    int addr_m = 0;
    logic [20:0] exp_q[$];     // {addr, data}
    logic fs_wrreq, fs_ovf;
    logic [AW-1:0] fs_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] stored(input logic [7:0] b);
`ifdef STN_CAP_INVERT_EN
        return ~b;
`else
        return b;
`endif
    endfunction

    task automatic expect_byte(input logic [7:0] b);
        exp_q.push_back({AW'(addr_m), stored(b)});
        addr_m = (addr_m + 1) % BUF_WORDS;
    endtask

    // Ack driver
    initial begin
        int zeros = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ack_mode)
                0: buf_wrack = 1'b0;
                1: buf_wrack = 1'b1;
                default: begin
                    if (zeros >= 3 || $urandom_range(1) == 1) begin
                        buf_wrack = 1'b1;
                        zeros = 0;
                    end else begin
                        buf_wrack = 1'b0;
                        zeros++;
                    end
                end
            endcase
        end
    end

    // Monitor: a write completes at the posedge following a negedge with req & ack high
    initial begin
        logic [20:0] e;
        forever begin
            @(negedge clk);
            if (rst_x && frame_start) begin
                fs_high++;
                fs_wrreq = buf_wrreq;
                fs_ovf = ovf_err;
                fs_addr = buf_waddr;
            end
            if (rst_x && buf_wrreq && buf_wrack) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_addr", {19'd0, buf_waddr}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("wdata", {24'd0, buf_wdata}, {24'd0, e[7:0]});
                    chk("waddr", {19'd0, buf_waddr}, {19'd0, e[20:8]});
                end
            end
        end
    end

    task automatic send_nibs(input logic [3:0] nibs[$]);
        foreach (nibs[i]) begin
            @(negedge clk);
            stn_fpdat = nibs[i];
            stn_fpshift = 1'b1;
            @(negedge clk);
            stn_fpshift = 1'b0;
        end
        repeat (4) @(negedge clk);
    endtask

    // Model: each line packs nibble pairs; only the first tcr bytes are written
    task automatic send_line(input logic [3:0] nibs[$], input int tcr);
        @(negedge clk);
        reg_tcr = 8'(tcr);
        for (int k = 0; k < nibs.size() / 2; k++)
            if (k < tcr) expect_byte({nibs[2*k], nibs[2*k+1]});
        send_nibs(nibs);
        @(negedge clk);
        stn_fpline = 1'b1;
        repeat (2) @(negedge clk);
        stn_fpline = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic do_frame();
        exp_q.delete();
        addr_m = 0;
        frames++;
        @(negedge clk);
        stn_fpframe = 1'b1;
        repeat (2) @(negedge clk);
        stn_fpline = 1'b1;
        repeat (2) @(negedge clk);
        stn_fpline = 1'b0;
        repeat (6) @(negedge clk);
        stn_fpframe = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk(name, exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [3:0] nq[$];
        int tcr;

        repeat (3) @(negedge clk);
        chk("rst_wrreq", {31'd0, buf_wrreq}, 0);
        chk("rst_waddr", {19'd0, buf_waddr}, 0);
        chk("rst_wdata", {24'd0, buf_wdata}, 0);
        chk("rst_frame_start", {31'd0, frame_start}, 0);
        chk("rst_ovf", {31'd0, ovf_err}, 0);
        rst_x = 1'b1;
        repeat (3) @(negedge clk);

        // Single byte A5
        ack_mode = 1;
        do_frame();
        nq = '{4'hA, 4'h5};
        send_line(nq, 1);
        drain("drain_a5");
        chk("waddr_after_a5", {19'd0, buf_waddr}, 1);

        // Column gate
        nq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
        send_line(nq, 2);
        drain("drain_tcr2");
        chk("ovf_tcr2", {31'd0, ovf_err}, 0);

        // Overflow with ack held low, then frame start flushes the pending request
        ack_mode = 0;
        @(negedge clk);
        reg_tcr = 8'd4;
        expect_byte(8'h9C);
        expect_byte(8'h37);
        nq = '{4'h9, 4'hC, 4'h3, 4'h7, 4'hE, 4'h1};
        send_nibs(nq);
        repeat (5) @(negedge clk);
        chk("ovf_set", {31'd0, ovf_err}, 1);
        chk("ovf_wrreq", {31'd0, buf_wrreq}, 1);
        chk("ovf_wdata_head", {24'd0, buf_wdata}, {24'd0, stored(8'h9C)});
        do_frame();
        chk("flush_wrreq", {31'd0, fs_wrreq}, 0);
        chk("flush_ovf", {31'd0, fs_ovf}, 0);
        chk("flush_waddr", {19'd0, fs_addr}, 0);
        ack_mode = 1;
        repeat (20) @(negedge clk);
        chk("flush_idle", {31'd0, buf_wrreq}, 0);

        // Polarity: F,0
        nq = '{4'hF, 4'h0};
        send_line(nq, 1);
        drain("drain_f0");

        // Address wrap: 25 lines of 240 bytes plus 80 more
        do_frame();
        for (int l = 0; l < 26; l++) begin
            nq.delete();
            for (int i = 0; i < (l == 25 ? 160 : 480); i++) nq.push_back(4'($urandom));
            send_line(nq, 240);
        end
        drain("drain_wrap");
        chk("waddr_wrapped", {19'd0, buf_waddr}, 0);

        // Random frames and lines
        ack_mode = 2;
        for (int f = 0; f < 4; f++) begin
            do_frame();
            for (int l = 0; l < 5; l++) begin
                nq.delete();
                for (int i = 0; i < int'($urandom_range(20)); i++) nq.push_back(4'($urandom));
                tcr = int'($urandom_range(8));
                send_line(nq, tcr);
            end
            drain("drain_rand");
            chk("ovf_rand", {31'd0, ovf_err}, 0);
        end

        chk("frame_start_cycles", fs_high, frames);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
